// File: rtl/prog_timer_if.sv
// prog_timer_if: configuration, control and status bundle of the programmable timer.
// The master modport is the driver side (CPU or bench).
// The slave modport is the timer itself.
interface prog_timer_if #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 4,
  parameter int PSC_WIDTH = 16
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [PSC_WIDTH-1:0] prescale;
  logic                 wr_en;
  logic [CH_W-1:0]      wr_ch;
  logic [WIDTH-1:0]     wr_period;
  logic [CHANNELS-1:0]  enable;
  logic [CHANNELS-1:0]  oneshot;
  logic [CHANNELS-1:0]  clear;
  logic [CHANNELS-1:0]  pulse;
  logic [CHANNELS-1:0]  flag;
  logic [CHANNELS-1:0]  running;

  modport master (
    output prescale, wr_en, wr_ch, wr_period, enable, oneshot, clear,
    input  pulse, flag, running
  );

  modport slave (
    input  prescale, wr_en, wr_ch, wr_period, enable, oneshot, clear,
    output pulse, flag, running
  );
endinterface

// File: rtl/prog_timer.sv
// prog_timer: multi-channel programmable interval timer.
// All channels share one prescaler, and each channel has its own period register and up-counter.
// A channel pulses for one clock at terminal count and sets a sticky flag.
// Optional feature: define PROG_TIMER_PRESCALER_EN to make ticks occur every prescale+1 clocks.
// Without PROG_TIMER_PRESCALER_EN, every clock is a tick and the prescale input is ignored.
module prog_timer #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 4,
  parameter int PSC_WIDTH = 16
) (
  input logic     clk,
  input logic     rst_n,
  prog_timer_if.slave bus
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                tick;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] terminal;
  logic [CHANNELS-1:0] running_q;
  logic [CHANNELS-1:0] pulse_q;
  logic [CHANNELS-1:0] flag_q;
  // High once enable has been seen low, so a following high level counts as a fresh rising edge.
  // Reset leaves it low, so a channel whose enable is held high through reset does not start.
  logic [CHANNELS-1:0] en_armed_q;
  logic [WIDTH-1:0]    count_q  [CHANNELS];
  logic [WIDTH-1:0]    period_q [CHANNELS];

`ifdef PROG_TIMER_PRESCALER_EN
  logic [PSC_WIDTH-1:0] psc_q;

  assign tick = (psc_q == bus.prescale);

  // Shared prescaler: counts 0..prescale and wraps, and a tick is the clock where it equals prescale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    psc_q <= '0;
    else if (tick) psc_q <= '0;
    else           psc_q <= psc_q + PSC_WIDTH'(1);
  end
`else
  logic unused_prescale;

  assign tick            = 1'b1;
  assign unused_prescale = ^bus.prescale;
`endif

  // Decode the period write; an index outside the channel range matches nothing.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++)
      wr_hit[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));
  end

  // Terminal count only for a channel that keeps running: no disable, no fresh start and no write this clock.
  always_comb begin
    terminal = '0;
    for (int i = 0; i < CHANNELS; i++)
      terminal[i] = bus.enable[i] && !en_armed_q[i] && !wr_hit[i] && running_q[i] &&
                    tick && (count_q[i] == period_q[i]);
  end

  // Period registers: loaded by the write strobe regardless of whether the channel is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) period_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        if (wr_hit[i]) period_q[i] <= bus.wr_period;
    end
  end

  // Per-channel counting. Priority order: disable, then fresh start, then write, then tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) count_q[i] <= '0;
      running_q  <= '0;
      pulse_q    <= '0;
      en_armed_q <= '0;
    end else begin
      en_armed_q <= ~bus.enable;
      for (int i = 0; i < CHANNELS; i++) begin
        pulse_q[i] <= terminal[i];
        if (!bus.enable[i]) begin
          running_q[i] <= 1'b0;
          count_q[i]   <= '0;
        end else if (en_armed_q[i]) begin
          running_q[i] <= 1'b1;
          count_q[i]   <= '0;
        end else if (wr_hit[i]) begin
          count_q[i] <= '0;
        end else if (terminal[i]) begin
          count_q[i] <= '0;
          if (bus.oneshot[i]) running_q[i] <= 1'b0;
        end else if (running_q[i] && tick) begin
          count_q[i] <= count_q[i] + WIDTH'(1);
        end
      end
    end
  end

  // Sticky flags: a terminal count wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (terminal[i])       flag_q[i] <= 1'b1;
        else if (bus.clear[i]) flag_q[i] <= 1'b0;
      end
    end
  end

  assign bus.pulse   = pulse_q;
  assign bus.flag    = flag_q;
  assign bus.running = running_q;
endmodule

// File: tb/tb_prog_timer.sv
// tb_prog_timer: self-checking bench for prog_timer.
// The bench contains directed vector tables, hand-written corner sequences and randomized traffic.
// Randomized traffic is compared against a behavioural model.
// Compile with or without PROG_TIMER_PRESCALER_EN; the expectations follow the same macro.
module tb_prog_timer;
  localparam int W  = 8;
  localparam int C  = 6;
  localparam int PW = 8;

  typedef struct {
    logic [C-1:0] en;
    logic [C-1:0] os;
    logic [C-1:0] clr;
    logic         we;
    logic [2:0]   wch;
    logic [W-1:0] wper;
    logic [C-1:0] ep;
    logic [C-1:0] ef;
    logic [C-1:0] er;
  } vec_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  prog_timer_if #(.WIDTH(W), .CHANNELS(C), .PSC_WIDTH(PW)) bus ();

  prog_timer #(.WIDTH(W), .CHANNELS(C), .PSC_WIDTH(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one record per channel, advanced once per clock from the timer's rules.
  int m_period [C];
  int m_count  [C];
  bit m_run    [C];
  bit m_flag   [C];
  bit m_armed  [C];
  bit m_pulse  [C];
  int m_clk;

  function automatic void model_reset();
    m_clk = 0;
    for (int i = 0; i < C; i++) begin
      m_period[i] = 0; m_count[i] = 0; m_run[i] = 0;
      m_flag[i]   = 0; m_armed[i] = 0; m_pulse[i] = 0;
    end
  endfunction

  function automatic void model_step();
    bit tick;
`ifdef PROG_TIMER_PRESCALER_EN
    int p;
    p    = int'(bus.prescale);
    tick = ((m_clk % (p + 1)) == p);
`else
    tick = 1'b1;
`endif
    m_clk++;
    for (int i = 0; i < C; i++) begin
      bit hit;
      bit tc;
      hit        = bus.wr_en && (int'(bus.wr_ch) == i);
      tc         = 1'b0;
      m_pulse[i] = 1'b0;
      if (!bus.enable[i]) begin
        m_run[i] = 0; m_count[i] = 0;
      end else if (m_armed[i]) begin
        m_run[i] = 1; m_count[i] = 0;
      end else if (hit) begin
        m_count[i] = 0;
      end else if (m_run[i] && tick) begin
        tc         = (m_count[i] == m_period[i]);
        m_count[i] = (m_count[i] + 1) % (m_period[i] + 1);
        if (tc) begin
          m_pulse[i] = 1'b1;
          if (bus.oneshot[i]) m_run[i] = 0;
        end
      end
      if (tc) m_flag[i] = 1'b1;
      else if (bus.clear[i]) m_flag[i] = 1'b0;
      m_armed[i] = !bus.enable[i];
      if (hit) m_period[i] = int'(bus.wr_period);
    end
  endfunction

  function automatic vec_t mk(logic [C-1:0] en, logic [C-1:0] os, logic [C-1:0] clr, logic we,
                              logic [2:0] wch, logic [W-1:0] wper,
                              logic [C-1:0] ep, logic [C-1:0] ef, logic [C-1:0] er);
    vec_t v;
    v.en = en; v.os = os; v.clr = clr; v.we = we; v.wch = wch; v.wper = wper;
    v.ep = ep; v.ef = ef; v.er = er;
    return v;
  endfunction

  task automatic applyStimulus(logic [C-1:0] en, logic [C-1:0] os, logic [C-1:0] clr,
                               logic we, logic [2:0] wch, logic [W-1:0] wper);
    bus.enable    = en;
    bus.oneshot   = os;
    bus.clear     = clr;
    bus.wr_en     = we;
    bus.wr_ch     = wch;
    bus.wr_period = wper;
  endtask

  task automatic checkOutput(string name, logic [C-1:0] ep, logic [C-1:0] ef, logic [C-1:0] er);
    vectors++;
    if (bus.pulse !== ep) begin
      miscompares++;
      $display("[TB] FAIL %s pulse got %b want %b", name, bus.pulse, ep);
    end
    vectors++;
    if (bus.flag !== ef) begin
      miscompares++;
      $display("[TB] FAIL %s flag got %b want %b", name, bus.flag, ef);
    end
    vectors++;
    if (bus.running !== er) begin
      miscompares++;
      $display("[TB] FAIL %s running got %b want %b", name, bus.running, er);
    end
  endtask

  task automatic checkModel(string name);
    logic [C-1:0] ep, ef, er;
    for (int i = 0; i < C; i++) begin
      ep[i] = m_pulse[i]; ef[i] = m_flag[i]; er[i] = m_run[i];
    end
    checkOutput(name, ep, ef, er);
  endtask

  // One clock: the model consumes the inputs, and outputs are then sampled 1 time unit after the edge.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[12];
  int   pe;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.prescale = '0;
    applyStimulus('0, '0, '0, 1'b0, 3'd0, '0);

    // Periodic channel 0, period 3: the first pulse is 5 clocks after the enable edge, then one every 4 clocks.
    tbl[0]  = mk(6'b000000, '0, '0,        1'b1, 3'd0, 8'd3, '0,        '0,        '0);
    tbl[1]  = mk(6'b000001, '0, '0,        1'b0, 3'd0, 8'd0, '0,        '0,        6'b000001);
    tbl[2]  = mk(6'b000001, '0, '0,        1'b0, 3'd0, 8'd0, '0,        '0,        6'b000001);
    tbl[3]  = mk(6'b000001, '0, '0,        1'b0, 3'd0, 8'd0, '0,        '0,        6'b000001);
    tbl[4]  = mk(6'b000001, '0, '0,        1'b0, 3'd0, 8'd0, '0,        '0,        6'b000001);
    tbl[5]  = mk(6'b000001, '0, '0,        1'b0, 3'd0, 8'd0, 6'b000001, 6'b000001, 6'b000001);
    tbl[6]  = mk(6'b000001, '0, '0,        1'b0, 3'd0, 8'd0, '0,        6'b000001, 6'b000001);
    tbl[7]  = mk(6'b000001, '0, '0,        1'b0, 3'd0, 8'd0, '0,        6'b000001, 6'b000001);
    tbl[8]  = mk(6'b000001, '0, '0,        1'b0, 3'd0, 8'd0, '0,        6'b000001, 6'b000001);
    tbl[9]  = mk(6'b000001, '0, '0,        1'b0, 3'd0, 8'd0, 6'b000001, 6'b000001, 6'b000001);
    tbl[10] = mk(6'b000001, '0, 6'b000001, 1'b0, 3'd0, 8'd0, '0,        '0,        6'b000001);
    tbl[11] = mk(6'b000000, '0, '0,        1'b0, 3'd0, 8'd0, '0,        '0,        '0);

    resetPulse();
    checkOutput("reset", '0, '0, '0);

    for (int k = 0; k < 12; k++) begin
      applyStimulus(tbl[k].en, tbl[k].os, tbl[k].clr, tbl[k].we, tbl[k].wch, tbl[k].wper);
      step();
      checkOutput($sformatf("tbl%0d", k), tbl[k].ep, tbl[k].ef, tbl[k].er);
    end

    // Channel 2, period 0: a clear on the same clock as a terminal count leaves the flag set.
    applyStimulus(6'b000100, '0, '0, 1'b1, 3'd2, 8'd0);
    step(); checkOutput("ch2_start", '0, '0, 6'b000100);
    applyStimulus(6'b000100, '0, '0, 1'b0, 3'd0, 8'd0);
    step(); checkOutput("ch2_tc", 6'b000100, 6'b000100, 6'b000100);
    applyStimulus(6'b000100, '0, 6'b000100, 1'b0, 3'd0, 8'd0);
    step(); checkOutput("ch2_clear_vs_tc", 6'b000100, 6'b000100, 6'b000100);
    applyStimulus(6'b000000, '0, 6'b000100, 1'b0, 3'd0, 8'd0);
    step(); checkOutput("ch2_clear", '0, '0, '0);

    // Channel 3: period 0 written while running, then out-of-range writes are ignored.
    applyStimulus(6'b001000, '0, '0, 1'b1, 3'd3, 8'd10);
    step(); checkOutput("ch3_start", '0, '0, 6'b001000);
    applyStimulus(6'b001000, '0, '0, 1'b0, 3'd0, 8'd0);
    repeat (3) step();
    checkOutput("ch3_counting", '0, '0, 6'b001000);
    applyStimulus(6'b001000, '0, '0, 1'b1, 3'd3, 8'd0);
    step(); checkOutput("ch3_write0", '0, '0, 6'b001000);
    applyStimulus(6'b001000, '0, '0, 1'b0, 3'd0, 8'd0);
    for (int k = 0; k < 3; k++) begin
      step(); checkOutput($sformatf("ch3_every_tick%0d", k), 6'b001000, 6'b001000, 6'b001000);
    end
    applyStimulus(6'b001000, '0, '0, 1'b1, 3'd7, 8'd5);
    step(); checkOutput("ch3_wr_ch7", 6'b001000, 6'b001000, 6'b001000);
    applyStimulus(6'b001000, '0, '0, 1'b1, 3'd6, 8'd5);
    step(); checkOutput("ch3_wr_ch6", 6'b001000, 6'b001000, 6'b001000);
    applyStimulus(6'b001000, '0, '0, 1'b0, 3'd0, 8'd0);
    step(); checkOutput("ch3_still_period0", 6'b001000, 6'b001000, 6'b001000);
    applyStimulus(6'b000000, '0, 6'b111111, 1'b0, 3'd0, 8'd0);
    step(); checkOutput("ch3_stop", '0, '0, '0);

    // Asynchronous reset mid-count: the channel must not restart until enable falls and rises again.
    applyStimulus(6'b000001, '0, '0, 1'b1, 3'd0, 8'd5);
    step();
    applyStimulus(6'b000001, '0, '0, 1'b0, 3'd0, 8'd0);
    step(); step();
    checkOutput("pre_reset", '0, '0, 6'b000001);
    #3 rst_n = 1'b0;
    #1 checkOutput("async_reset", '0, '0, '0);
    resetPulse();
    for (int k = 0; k < 5; k++) begin
      step(); checkOutput($sformatf("held_enable%0d", k), '0, '0, '0);
    end
    applyStimulus(6'b000000, '0, '0, 1'b0, 3'd0, 8'd0);
    step();
    applyStimulus(6'b000001, '0, '0, 1'b0, 3'd0, 8'd0);
    step(); checkOutput("restart", '0, '0, 6'b000001);
    step(); checkOutput("restart_period0", 6'b000001, 6'b000001, 6'b000001);

    // One-shot channel 1, period 1, prescale 2: a single pulse, then idle until enable is toggled.
`ifdef PROG_TIMER_PRESCALER_EN
    pe = 6;
`else
    pe = 4;
`endif
    applyStimulus('0, '0, '0, 1'b0, 3'd0, 8'd0);
    bus.prescale = PW'(2);
    resetPulse();
    applyStimulus('0, 6'b000010, '0, 1'b1, 3'd1, 8'd1);
    step(); checkOutput("os_k1", '0, '0, '0);
    applyStimulus(6'b000010, 6'b000010, '0, 1'b0, 3'd0, 8'd0);
    for (int k = 2; k <= 20; k++) begin
      step();
      checkOutput($sformatf("os_k%0d", k),
                  (k == pe) ? 6'b000010 : 6'b000000,
                  (k >= pe) ? 6'b000010 : 6'b000000,
                  (k >= 2 && k < pe) ? 6'b000010 : 6'b000000);
    end
    applyStimulus(6'b000000, 6'b000010, '0, 1'b0, 3'd0, 8'd0);
    step(); checkOutput("os_low", '0, 6'b000010, '0);
    applyStimulus(6'b000010, 6'b000010, '0, 1'b0, 3'd0, 8'd0);
    step(); checkOutput("os_rearm", '0, 6'b000010, 6'b000010);

    // Randomized traffic against the model, with a fresh reset and a fixed prescale per segment.
    for (int seg = 0; seg < 4; seg++) begin
      logic [C-1:0] en;
      logic [C-1:0] os;
      applyStimulus('0, '0, '0, 1'b0, 3'd0, 8'd0);
      bus.prescale = (seg == 0) ? PW'(5) : PW'($urandom_range(0, 3));
      resetPulse();
      en = '0;
      os = C'($urandom);
      for (int k = 0; k < 300; k++) begin
        for (int i = 0; i < C; i++)
          if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
        if ($urandom_range(0, 31) == 0) os = C'($urandom);
        applyStimulus(en, os, C'($urandom & $urandom & $urandom),
                      ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                      W'($urandom_range(0, 6)));
        step();
        checkModel($sformatf("rand_s%0d_c%0d", seg, k));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
